uart_tx_parity: RTL and testbench

UART serial transmitter with optional parity-bit generation. It is the transmit-side counterpart of the receive path's parity checker and uses the same parity conventions.
Accepts a parallel byte on a start strobe and shifts out the frame: start bit, data bits LSB first, optional parity bit, one stop bit. Each bit is held for a fixed number of clocks.
Sits between the host/control logic and the TX pin. It drives the line that the remote receiver and parity checker sample.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_parity_if.sv | 30 +++
 rtl/uart_baud_counter.sv | 43 ++++
 rtl/uart_tx_parity.sv | 139 +++++++++++++
 tb/tb_uart_tx_parity.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART state encoding, parity-type constants and defaults.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // 50 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_parity_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity_if
// Brief    : Host-side request/status bundle and TX line of the transmitter.
// Revision : 1.0
// ============================================================================
interface uart_tx_parity_if #(
  parameter int DATA_BITS = 8
);

  logic                 use_parity;
  logic                 parity_type;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 serial_out;

  modport master (
    output use_parity, parity_type, tx_start, tx_data,
    input  tx_busy, tx_done, serial_out
  );

  modport slave (
    input  use_parity, parity_type, tx_start, tx_data,
    output tx_busy, tx_done, serial_out
  );

endinterface : uart_tx_parity_if
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_counter
// Brief    : Bit-period counter; bit_tick_o marks the last clock of each bit.
// Revision : 1.0
// ============================================================================
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = !clear_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || bit_tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity
// Brief    : UART transmitter: start, LSB-first data, optional parity, stop.
// Revision : 1.0
// ============================================================================
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_parity_if.slave      bus
);

  localparam int            BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 par_en_q, par_en_d;
  logic                 par_type_q, par_type_d;
  logic                 serial_q, serial_d;
  logic                 done_q, done_d;
  logic                 bit_tick;
  logic                 parity_bit;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (state_q == IDLE),
    .bit_tick_o (bit_tick)
  );

  // Taken from the frozen copy of the byte, never the live input
  assign parity_bit = (^data_q) ^ (par_type_q == PARITY_ODD);

  assign bus.tx_busy    = (state_q != IDLE);
  assign bus.tx_done    = done_q;
  assign bus.serial_out = serial_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    serial_d   = serial_q;
    done_d     = 1'b0;

    // serial_d always reflects the bit of the state being entered
    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        bit_d    = '0;
        if (bus.tx_start) begin
          state_d    = START;
          data_d     = bus.tx_data;
          shift_d    = bus.tx_data;
          par_en_d   = bus.use_parity;
          par_type_d = bus.parity_type;
          serial_d   = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d  = DATA;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (par_en_q) begin
              state_d  = PARITY;
              serial_d = parity_bit;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_d  = IDLE;
          serial_d = 1'b1;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= PARITY_EVEN;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
    end
  end

endmodule : uart_tx_parity
`default_nettype wire

// File: tb/tb_uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_parity
// Brief    : Directed and random frames checked against an expected bit list.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_parity;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart_tx_parity_if #(.DATA_BITS(DB)) bus ();

  uart_tx_parity #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // obs/exp are {tx_busy, tx_done, serial_out}
  task automatic chk(input logic [2:0] obs, input logic [2:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed busy/done/line=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {bus.tx_busy, bus.tx_done, bus.serial_out};
  endfunction

  // Expected line levels of one frame, one entry per bit
  function automatic void build_bits(input logic [7:0] d, input logic en, input logic odd,
                                     ref logic bits[$]);
    int ones;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (en) begin
      ones = $countones(d);
      bits.push_back(odd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
    end
    bits.push_back(1'b1);
  endfunction

  // Called on the first start-bit cycle; returns on the tx_done cycle
  // (or at cycle abort_at without checking it).
  task automatic check_frame(input logic [7:0] d, input logic en, input logic odd,
                             input int inject_at, input int abort_at, input string tag);
    logic bits[$];
    int   idx;
    build_bits(d, en, odd, bits);
    idx = 0;
    foreach (bits[b]) begin
      for (int c = 0; c < CPB; c++) begin
        if (idx == abort_at) return;
        chk(outs(), {1'b1, 1'b0, bits[b]}, $sformatf("%s bit%0d cyc%0d", tag, b, c));
        if (idx == inject_at) begin
          bus.tx_start = 1'b1;
          bus.tx_data  = 8'hFF;
        end
        if (inject_at >= 0 && idx == inject_at + 4) bus.tx_start = 1'b0;
        tick();
        idx++;
      end
    end
    chk(outs(), 3'b011, {tag, " done"});
  endtask

  // Accept a frame, then scramble the live inputs to prove they are latched
  task automatic send(input logic [7:0] d, input logic en, input logic odd);
    bus.tx_data     = d;
    bus.use_parity  = en;
    bus.parity_type = odd;
    bus.tx_start    = 1'b1;
    tick();
    bus.tx_start    = 1'b0;
    bus.tx_data     = 8'($urandom);
    bus.use_parity  = 1'($urandom);
    bus.parity_type = 1'($urandom);
  endtask

  initial begin
    logic [7:0] rd;
    logic       ren;
    logic       rodd;
    checks = 0;
    errors = 0;
    bus.tx_start    = 1'b0;
    bus.tx_data     = '0;
    bus.use_parity  = 1'b0;
    bus.parity_type = PARITY_EVEN;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) chk(outs(), 3'b001, $sformatf("idle after reset %0d", i));

    send(8'h55, 1'b0, PARITY_EVEN);
    check_frame(8'h55, 1'b0, PARITY_EVEN, -1, -1, "f55");
    tick();
    chk(outs(), 3'b001, "f55 single done");

    send(8'h07, 1'b1, PARITY_EVEN);
    check_frame(8'h07, 1'b1, PARITY_EVEN, -1, -1, "f07even");
    tick();
    send(8'h07, 1'b1, PARITY_ODD);
    check_frame(8'h07, 1'b1, PARITY_ODD, -1, -1, "f07odd");
    tick();
    send(8'h00, 1'b1, PARITY_EVEN);
    check_frame(8'h00, 1'b1, PARITY_EVEN, -1, -1, "f00even");
    tick();

    // Start request with a different byte during data bit 2 must be ignored
    send(8'hA3, 1'b0, PARITY_EVEN);
    check_frame(8'hA3, 1'b0, PARITY_EVEN, 13, -1, "fA3");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk(outs(), 3'b001, $sformatf("fA3 no requeue %0d", i));
    end

    // Reset in the middle of data bit 3 abandons the frame
    send(8'($urandom), 1'b1, PARITY_ODD);
    check_frame(8'h00, 1'b0, PARITY_EVEN, -1, 1, "pre-abort");
    reset = 1'b1;
    tick();
    chk(outs(), 3'b001, "no abort before reset");
    tick();
    tick();
    for (int i = 0; i < 16; i++) tick();
    reset = 1'b0;
    tick();
    send(8'hC5, 1'b1, PARITY_EVEN);
    check_frame(8'hC5, 1'b1, PARITY_EVEN, -1, 17, "fC5 partial");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk(outs(), 3'b001, "reset mid-frame");
    tick();
    chk(outs(), 3'b001, "reset no done");
    tick();
    send(8'h3C, 1'b0, PARITY_EVEN);
    check_frame(8'h3C, 1'b0, PARITY_EVEN, -1, -1, "f3C");
    tick();

    // Held start: second byte is accepted on the tx_done cycle
    bus.tx_data    = 8'h81;
    bus.use_parity = 1'b0;
    bus.tx_start   = 1'b1;
    tick();
    bus.tx_data    = 8'h42;
    check_frame(8'h81, 1'b0, PARITY_EVEN, -1, -1, "f81");
    tick();
    bus.tx_start   = 1'b0;
    check_frame(8'h42, 1'b0, PARITY_EVEN, -1, -1, "f42");
    tick();

    for (int n = 0; n < 6; n++) begin
      rd   = 8'($urandom);
      ren  = 1'($urandom);
      rodd = 1'($urandom);
      send(rd, ren, rodd);
      check_frame(rd, ren, rodd, -1, -1, $sformatf("rnd%0d", n));
      tick();
      chk(outs(), 3'b001, $sformatf("rnd%0d idle", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_parity
`default_nettype wire
